// File: rtl/serial_and_rx_if.sv
// Handshake bundle for serial_and_rx: the serial (a, b) beat stream going in,
// and the assembled word with its valid/ready pair coming out.
// With SERIAL_AND_RX_PARITY_EN defined, the bundle also carries q_par.
interface serial_and_rx_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             a;
  logic             b;
  logic             in_ready;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
`ifdef SERIAL_AND_RX_PARITY_EN
  logic             q_par;
`endif

  // The block itself: it consumes beats and produces words
  modport slave (
    input  in_valid,
    input  a,
    input  b,
    output in_ready,
    output q,
    output q_valid,
`ifdef SERIAL_AND_RX_PARITY_EN
    output q_par,
`endif
    input  q_ready
  );

  // The surrounding logic: it offers beats and takes words
  modport master (
    output in_valid,
    output a,
    output b,
    input  in_ready,
    input  q,
    input  q_valid,
`ifdef SERIAL_AND_RX_PARITY_EN
    input  q_par,
`endif
    output q_ready
  );

endinterface

// File: rtl/serial_and_rx.sv
// serial_and_rx: collects WIDTH serial beats of (a, b), LSB first, into a word
// of a&b bits, then holds that word until the downstream side takes it.
// Optional feature: define SERIAL_AND_RX_PARITY_EN to add q_par, the XOR of
// all q bits. Without the macro the block has no q_par at all.
module serial_and_rx #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  serial_and_rx_if.slave bus
);

  // One extra bit so the counter can represent WIDTH itself
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CW-1:0]    r_beatCount;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_qNext;
  logic             w_inReady;
  logic             w_qValid;
  logic             w_accept;
  logic             w_outTake;

  assign w_accept  = bus.in_valid && w_inReady;
  assign w_outTake = w_qValid && bus.q_ready;

  // State register; reset outranks clr, and both abandon any word in progress
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: the beat that fills the top bit closes the word; a taken word reopens collection
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      COLLECT: begin
        if (w_accept && (r_beatCount == CW'(WIDTH - 1))) begin
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        if (w_outTake) begin
          w_nextState = COLLECT;
        end
      end
      default: w_nextState = COLLECT;
    endcase
  end

  // Outputs decoded from state; in_ready also drops while reset is asserted
  always_comb begin
    w_inReady = (r_state == COLLECT) && rst_n;
    w_qValid  = (r_state == HOLD);
  end

  // Place the incoming a&b bit at the slot selected by the beat counter
  always_comb begin
    w_qNext = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_beatCount == CW'(i)) begin
        w_qNext[i] = bus.a & bus.b;
      end
    end
  end

  // Word and counter; a taken word is zeroed so the next one starts clean at bit 0
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_beatCount <= '0;
      r_q         <= '0;
    end else if (w_outTake) begin
      r_beatCount <= '0;
      r_q         <= '0;
    end else if (w_accept) begin
      r_beatCount <= r_beatCount + CW'(1);
      r_q         <= w_qNext;
    end
  end

  assign bus.in_ready = w_inReady;
  assign bus.q_valid  = w_qValid;
  assign bus.q        = r_q;
`ifdef SERIAL_AND_RX_PARITY_EN
  assign bus.q_par    = ^r_q;
`endif

endmodule

// File: doc/serial_and_rx.md
SERIAL_AND_RX -- requirements
Module: serial_and_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the number of result bits per word (legal range 2..32).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-004 SHALL have port clr  input  1  synchronous discard of any partial or held word.
REQ-005 SHALL have port in_valid  input  1  serial beat (a, b) present.
REQ-006 SHALL have port a  input  1  serial operand A bit, LSB first.
REQ-007 SHALL have port b  input  1  serial operand B bit, LSB first.
REQ-008 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-009 SHALL have port q  output  WIDTH  assembled word of a&b bits.
REQ-010 SHALL have port q_valid  output  1  q holds a complete word.
REQ-011 SHALL have port q_ready  input  1  downstream takes q this cycle.

Function
REQ-012 SHALL implement two states: COLLECT (in_ready=1, q_valid=0) and HOLD (in_ready=0, q_valid=1).
REQ-013 SHALL accept a beat only when in_valid=1 and in_ready=1 in the same cycle.
REQ-014 SHALL write a&b of the k-th accepted beat (k=0..WIDTH-1) into q[k]; bit 0 first.
REQ-015 SHALL keep a beat counter of width ceil(log2(WIDTH))+1, incrementing once per accepted beat.
REQ-016 SHALL move COLLECT->HOLD on the clock edge that accepts beat WIDTH-1, so q_valid rises the cycle after the last beat (latency 1).
REQ-017 SHALL hold q and q_valid stable in HOLD until q_valid=1 and q_ready=1 in the same cycle.
REQ-018 SHALL move HOLD->COLLECT on that handshake, clearing the counter, with in_ready=1 the following cycle.
REQ-019 SHALL ignore in_valid, a and b while in HOLD; no bit of q changes.
REQ-020 SHALL treat in_valid=0 cycles in COLLECT as stalls: counter and q unchanged.
REQ-021 SHALL, on clr=1, go to COLLECT, zero counter and q, and deassert q_valid next cycle; clr overrides a simultaneous beat or output handshake.
REQ-022 SHALL keep bits q[WIDTH-1:k] at 0 while k beats of a partial word have been accepted.

Reset
REQ-023 SHALL, on rising clk with rst_n=0, enter COLLECT with counter=0, q=0, q_valid=0, in_ready=1 from the following cycle.
REQ-024 SHALL let rst_n=0 abort a partial or held word identically to clr, with reset taking priority over clr.
REQ-025 SHALL drive in_ready=0 during the cycles rst_n=0 is sampled low.

Configuration
REQ-026 SHALL, with macro SERIAL_AND_RX_PARITY_EN defined, add output port q_par (1 bit) equal to the XOR of all q bits, valid whenever q_valid=1 and 0 after reset or clr.
REQ-027 SHALL, without SERIAL_AND_RX_PARITY_EN, omit q_par entirely, with all other behaviour unchanged.

Verification (WIDTH=8)
REQ-028 SHALL check the basic word: a=8'hF0, b=8'h3C sent LSB first on 8 consecutive cycles -> q_valid=1 the cycle after beat 7, q=8'h30, q_par=0.
REQ-029 SHALL check stalls: the same word with in_valid=0 for 3 cycles after beat 3 -> q=8'h30, q_valid rises exactly one cycle after the last accepted beat.
REQ-030 SHALL check backpressure: q_ready=0 for 5 cycles after q_valid, with extra beats a=b=1 offered -> in_ready=0, q stays 8'h30, and the next word after q_ready=1 starts at q[0].
REQ-031 SHALL check clear: clr=1 after 5 beats of a=b=8'hFF -> q=0 and counter=0; a following full word a=b=8'h01 gives q=8'h01, q_par=1.
REQ-032 SHALL check reset mid-word: rst_n=0 for 1 cycle during beat 4 -> q=0, q_valid=0, in_ready=1 after release, and the next 8 beats form a full word.
REQ-033 SHALL check simultaneous events: clr=1 together with q_valid=1 and q_ready=1 -> COLLECT, q=0, q_valid=0, and no extra word produced.
